// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between a bus-side writer and a UART emitter.
// Writer pushes with wr_en when not full; emitter pops with a tx_valid/tx_ready
// handshake. Pushes while full are dropped and latch the sticky overflow flag.
// Optional feature: define UART_TX_FIFO_FLUSH_EN to add a single-cycle flush
// input that empties the FIFO (pointers and level) without touching overflow.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          wr_full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready
`ifdef UART_TX_FIFO_FLUSH_EN
    ,
    input  logic          flush
`endif
);

    localparam int DATA_W = 8;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // Storage is deliberately not reset; only the control state below is.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   lvl;
    logic          ovf;

    logic push;
    logic pop;
    logic drop;
    logic flush_req;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign wr_full  = (lvl == FULL_LVL);
    assign empty    = (lvl == '0);
    assign level    = lvl;
    assign overflow = ovf;
    assign tx_valid = !empty;
    assign tx_data  = mem[rptr];

    // A push while full is a drop even if the emitter pops in the same cycle.
    assign push = wr_en && !wr_full;
    assign drop = wr_en && wr_full;
    assign pop  = tx_valid && tx_ready;

    // Write the incoming byte into the slot under the write pointer.
    always_ff @(posedge clk) begin
        if (rst && push && !flush_req) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
        end else if (flush_req) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + (AW+1)'(1);
                2'b01:   lvl <= lvl - (AW+1)'(1);
                default: lvl <= lvl;
            endcase
        end
    end

    // Sticky overflow: a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a queue-based model.
// Define UART_TX_FIFO_FLUSH_EN for both files to exercise the flush input.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clr;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          flush_i;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_full  (wr_full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
`ifdef UART_TX_FIFO_FLUSH_EN
        ,
        .flush    (flush_i)
`endif
    );

    // Reference model: contents as a queue, plus the sticky flag.
    logic [7:0] mq [$];
    logic [7:0] popped [$];
    bit         m_ovf;
    bit         m_pushed;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: update model from the inputs held across the edge,
    // then compare every DUT output against the model on the falling edge.
    task automatic cycle();
        bit full;
        bit do_pop;
        bit do_push;
        @(posedge clk);
        m_pushed = 1'b0;
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            full    = (mq.size() == DEPTH);
            do_pop  = (mq.size() != 0) && tx_ready;
            do_push = wr_en && !full;
            if (wr_en && full) m_ovf = 1'b1;
            else if (ovf_clr)  m_ovf = 1'b0;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (do_pop)  popped.push_back(mq.pop_front());
                if (do_push) begin
                    mq.push_back(wr_data);
                    m_pushed = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("level",    32'(level),    32'(mq.size()));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("wr_full",  32'(wr_full),  32'(mq.size() == DEPTH));
        check("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) check("tx_data", 32'(tx_data), 32'(mq[0]));
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    logic [7:0] exp3 [3];
    int         idx;
    int         guard;

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        tx_ready = 1'b0; flush_i = 1'b0;
        exp3[0] = 8'h41; exp3[1] = 8'h42; exp3[2] = 8'h43;
        @(negedge clk);

        // Reset state
        cycle();
        check("rst_level",    32'(level),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(wr_full),  32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        cycle();

        // Three pushes with the emitter stalled
        push_byte(8'h41);
        check("latency_tx_valid", 32'(tx_valid), 32'd1);
        push_byte(8'h42);
        push_byte(8'h43);
        check("three_level",   32'(level),   32'd3);
        check("three_tx_data", 32'(tx_data), 32'h41);

        // Drain in order
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_order", 32'(tx_data), 32'(exp3[i]));
            cycle();
        end
        check("drain_empty",    32'(empty),    32'd1);
        check("drain_tx_valid", 32'(tx_valid), 32'd0);
        check("drain_level",    32'(level),    32'd0);
        cycle();
        check("underflow_level", 32'(level), 32'd0);
        tx_ready = 1'b0;

        // Fill, then push while full with a same-cycle pop
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        check("fill_full",  32'(wr_full), 32'd1);
        check("fill_level", 32'(level),   32'd16);
        wr_en = 1'b1; wr_data = 8'hFF; tx_ready = 1'b1;
        cycle();
        wr_en = 1'b0; tx_ready = 1'b0;
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_level",    32'(level),    32'd15);
        check("drop_head",     32'(tx_data),  32'h11);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Set wins over clear
        push_byte(8'h20);
        wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
        cycle();
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        tx_ready = 1'b0;
        check("refill_drained", 32'(level), 32'd0);

        // 40 bytes with random handshakes
        popped.delete();
        idx = 0;
        guard = 0;
        while ((popped.size() < 40) && (guard < 2000)) begin
            wr_en    = (idx < 40) && ($urandom_range(0, 1) == 1);
            wr_data  = 8'(idx);
            tx_ready = ($urandom_range(0, 1) == 1);
            cycle();
            if (m_pushed) idx++;
            guard++;
        end
        wr_en = 1'b0; tx_ready = 1'b0;
        check("stream_count", 32'(popped.size()), 32'd40);
        for (int k = 0; k < 40; k++) begin
            if (k < popped.size()) check("stream_byte", 32'(popped[k]), 32'(k));
        end

        // Mid-operation reset with a concurrent push and overflow set
        for (int i = 0; i < DEPTH; i++) push_byte(8'h60 + 8'(i));
        push_byte(8'h99);
        tx_ready = 1'b1;
        for (int i = 0; i < 11; i++) cycle();
        tx_ready = 1'b0;
        check("pre_rst_level", 32'(level),    32'd5);
        check("pre_rst_ovf",   32'(overflow), 32'd1);
        rst = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
        cycle();
        rst = 1'b1; wr_en = 1'b0;
        check("midrst_level",    32'(level),    32'd0);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);

`ifdef UART_TX_FIFO_FLUSH_EN
        // Flush beats a same-cycle push and pop
        for (int i = 0; i < 7; i++) push_byte(8'h30 + 8'(i));
        check("preflush_level", 32'(level), 32'd7);
        flush_i = 1'b1; wr_en = 1'b1; wr_data = 8'hAA; tx_ready = 1'b1;
        cycle();
        flush_i = 1'b0; wr_en = 1'b0; tx_ready = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        push_byte(8'h5A);
        check("postflush_data", 32'(tx_data), 32'h5A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
